// File: rtl/mainfsm_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } statetype;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mainfsm_instr_counter.sv
// Retired-instruction counter: wraps silently, cleared asynchronously.
module instr_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mainfsm.sv
// Multicycle ARM main controller: steps each instruction through its states,
// drives datapath selects/strobes, and counts retired instructions.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             Retire,
  output logic [CNT_W-1:0] InstrCount
);

  statetype state_q;
  logic     funct_unused;

  assign funct_unused = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:    if (MemReady) state_q <= DECODE;
        DECODE: begin
          case (Op)
            OP_DP:   state_q <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_MEM:  state_q <= MEMADR;
            OP_BR:   state_q <= BRANCH;
            default: state_q <= FETCH;
          endcase
        end
        MEMADR:   state_q <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (MemReady) state_q <= MEMWB;
        MEMWRITE: if (MemReady) state_q <= FETCH;
        EXECUTER: state_q <= ALUWB;
        EXECUTEI: state_q <= ALUWB;
        // MEMWB, ALUWB, BRANCH and any illegal encoding return to FETCH
        default:  state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Retire    = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_RDATA;
        RegW      = 1'b1;
        Retire    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        Retire = MemReady;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW   = 1'b1;
        Retire = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
        Retire    = 1'b1;
      end
      default: ;
    endcase
    // State is already FETCH during reset; strobes must also drop without an edge
    if (!reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
      Retire  = 1'b0;
    end
  end

  instr_counter #(
    .CNT_W(CNT_W)
  ) u_instr_counter (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (Retire),
    .count_o(InstrCount)
  );

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed table, random instruction stream,
// asynchronous reset mid-store and counter wrap.
module tb_mainfsm;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          MemReady;
  logic          IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, Retire;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc;
  logic [CW-1:0] InstrCount;

  mainfsm #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .Retire    (Retire),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BR} phase_e;

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       aop;
    logic       rw;
    logic       mw;
    logic       br;
    logic       ret;
  } out_t;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    int unsigned fw;
    int unsigned rw;
    int unsigned ww;
  } vec_t;

  out_t          dut_out;
  int            vectors = 0;
  int            errors  = 0;
  logic [CW-1:0] mcnt;

  assign dut_out = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    ALUOp, RegW, MemW, Branch, Retire};

  function automatic out_t expect_out(phase_e p, logic mr);
    out_t o;
    o = '0;
    case (p)
      P_F:   begin o.sa = 2'b01; o.sb = 2'b10; o.rs = 2'b10; o.irw = mr; o.npc = mr; end
      P_D:   begin o.sa = 2'b01; o.sb = 2'b10; o.rs = 2'b10; end
      P_MA:  begin o.sb = 2'b01; end
      P_MR:  begin o.adr = 1'b1; end
      P_MWB: begin o.rs = 2'b01; o.rw = 1'b1; o.ret = 1'b1; end
      P_MW:  begin o.adr = 1'b1; o.mw = 1'b1; o.ret = mr; end
      P_ER:  begin o.aop = 1'b1; end
      P_EI:  begin o.sb = 2'b01; o.aop = 1'b1; end
      P_AWB: begin o.rw = 1'b1; o.ret = 1'b1; end
      P_BR:  begin o.sb = 2'b01; o.rs = 2'b10; o.br = 1'b1; o.ret = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string nm, input out_t exp, input logic [CW-1:0] ecnt);
    vectors++;
    if (dut_out !== exp || InstrCount !== ecnt) begin
      errors++;
      $display("FAIL %s @%0t: outputs=%b count=%0d, expected outputs=%b count=%0d",
               nm, $time, dut_out, InstrCount, exp, ecnt);
    end
  endtask

  // Expand one instruction into its per-cycle phase list, then apply and check it
  task automatic run_instr(input vec_t v);
    phase_e ph[$];
    logic   mrq[$];
    out_t   e;
    for (int unsigned i = 0; i < v.fw; i++) begin ph.push_back(P_F); mrq.push_back(1'b0); end
    ph.push_back(P_F); mrq.push_back(1'b1);
    ph.push_back(P_D); mrq.push_back(1'($urandom_range(0, 1)));
    case (v.op)
      2'b00: begin
        ph.push_back(v.funct[5] ? P_EI : P_ER); mrq.push_back(1'($urandom_range(0, 1)));
        ph.push_back(P_AWB);                    mrq.push_back(1'($urandom_range(0, 1)));
      end
      2'b01: begin
        ph.push_back(P_MA); mrq.push_back(1'($urandom_range(0, 1)));
        if (v.funct[0]) begin
          for (int unsigned i = 0; i < v.rw; i++) begin ph.push_back(P_MR); mrq.push_back(1'b0); end
          ph.push_back(P_MR);  mrq.push_back(1'b1);
          ph.push_back(P_MWB); mrq.push_back(1'($urandom_range(0, 1)));
        end else begin
          for (int unsigned i = 0; i < v.ww; i++) begin ph.push_back(P_MW); mrq.push_back(1'b0); end
          ph.push_back(P_MW); mrq.push_back(1'b1);
        end
      end
      2'b10: begin
        ph.push_back(P_BR); mrq.push_back(1'($urandom_range(0, 1)));
      end
      default: ;
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      Op       = v.op;
      Funct    = v.funct;
      MemReady = mrq[i];
      #1;
      e = expect_out(ph[i], mrq[i]);
      check(ph[i].name(), e, mcnt);
      if (e.ret) mcnt = mcnt + 1'b1;
    end
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    tbl[0] = '{op: 2'b00, funct: 6'b001000, fw: 0, rw: 0, ww: 0};
    tbl[1] = '{op: 2'b01, funct: 6'b011001, fw: 0, rw: 2, ww: 0};
    tbl[2] = '{op: 2'b01, funct: 6'b011000, fw: 0, rw: 0, ww: 1};
    tbl[3] = '{op: 2'b10, funct: 6'b000000, fw: 0, rw: 0, ww: 0};
    tbl[4] = '{op: 2'b11, funct: 6'b000000, fw: 0, rw: 0, ww: 0};
    tbl[5] = '{op: 2'b00, funct: 6'b101010, fw: 1, rw: 0, ww: 0};

    reset    = 1'b0;
    Op       = 2'b00;
    Funct    = '0;
    MemReady = 1'b1;
    mcnt     = '0;
    #1;
    check("reset_hold", expect_out(P_F, 1'b0), '0);
    @(negedge clk);
    check("reset_after_edge", expect_out(P_F, 1'b0), '0);
    MemReady = 1'b0;
    reset    = 1'b1;

    for (int i = 0; i < 6; i++) run_instr(tbl[i]);

    for (int i = 0; i < 60; i++) begin
      v.op    = 2'($urandom_range(0, 3));
      v.funct = 6'($urandom);
      v.fw    = $urandom_range(0, 2);
      v.rw    = $urandom_range(0, 2);
      v.ww    = $urandom_range(0, 2);
      run_instr(v);
    end

    // Asynchronous reset in the middle of a stalled store
    @(negedge clk);
    Op = 2'b01; Funct = 6'b011000; MemReady = 1'b1;
    #1 check("str_fetch", expect_out(P_F, 1'b1), mcnt);
    @(negedge clk);
    #1 check("str_decode", expect_out(P_D, 1'b1), mcnt);
    @(negedge clk);
    #1 check("str_memadr", expect_out(P_MA, 1'b1), mcnt);
    @(negedge clk);
    MemReady = 1'b0;
    #1 check("str_memwrite", expect_out(P_MW, 1'b0), mcnt);
    reset    = 1'b0;
    MemReady = 1'b1;
    mcnt     = '0;
    #1 check("reset_async", expect_out(P_F, 1'b0), mcnt);
    @(negedge clk);
    MemReady = 1'b0;
    reset    = 1'b1;
    #1 check("reset_release", expect_out(P_F, 1'b0), mcnt);
    run_instr(tbl[0]);

    // Drive the counter to all-ones with branches, then retire once more
    v = '{op: 2'b10, funct: 6'b000000, fw: 0, rw: 0, ww: 0};
    while (mcnt != '1) run_instr(v);
    @(negedge clk);
    MemReady = 1'b0;
    #1 check("count_all_ones", expect_out(P_F, 1'b0), mcnt);
    run_instr(v);
    @(negedge clk);
    MemReady = 1'b0;
    #1 check("count_wrap", expect_out(P_F, 1'b0), mcnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle main controller for the ARM datapath. It walks each instruction through the fetch, decode, execute, memory and writeback steps, and drives the datapath mux selects and write enables for each step. Its raw RegW, MemW and Branch outputs feed the condition logic, which gates them with the condition check before they reach the register file, memory and PC. It also waits on a memory-ready handshake and keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]; Funct[5] is I, Funct[0] is S/L.
- MemReady  in  1  memory has completed the current access this cycle.
- IRWrite  out  1  load the instruction register.
- NextPC  out  1  PC update request (raw, not condition-gated).
- AdrSrc  out  1  0 selects PC as address, 1 selects ALU result.
- ALUSrcA  out  2  ALU A select: 00 is register, 01 is PC.
- ALUSrcB  out  2  ALU B select: 00 is register, 01 is immediate, 10 is constant 4.
- ResultSrc  out  2  result select: 00 is ALUOut, 01 is read data, 10 is ALU result.
- ALUOp  out  1  1 means the ALU decoder uses Funct; 0 forces ADD.
- RegW  out  1  raw register write.
- MemW  out  1  raw memory write.
- Branch  out  1  raw branch.
- Retire  out  1  one-cycle pulse when an instruction completes.
- InstrCount  out  CNT_W  count of retired instructions.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.

Transitions:
- FETCH goes to DECODE when MemReady=1; otherwise it holds.
- DECODE goes to:
  - MEMADR when Op=01.
  - EXECUTER when Op=00 and Funct[5]=0.
  - EXECUTEI when Op=00 and Funct[5]=1.
  - BRANCH when Op=10.
  - FETCH when Op=11 (undefined). This path does not retire.
- MEMADR goes to MEMREAD when Funct[0]=1, otherwise to MEMWRITE.
- MEMREAD goes to MEMWB when MemReady=1; otherwise it holds.
- MEMWRITE goes to FETCH when MemReady=1; otherwise it holds.
- MEMWB, ALUWB and BRANCH go to FETCH.
- EXECUTER and EXECUTEI go to ALUWB.

Outputs are Moore-style and decoded from state. Any signal not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite and NextPC equal MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. This reads PC+8.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. MemW stays high for every cycle spent in the state.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.

Retire and InstrCount:
- Retire=1 in MEMWB, ALUWB and BRANCH, and in MEMWRITE when MemReady=1.
- InstrCount increments on each clock edge where Retire=1.
- InstrCount wraps from all-ones to 0 without a flag.

## Timing
- Reset:
  - While reset=0, the state is forced to FETCH and InstrCount to 0, immediately.
  - While reset=0, IRWrite, NextPC, RegW, MemW, Branch and Retire are forced to 0. The mux selects show their FETCH values.
- Reset asserted mid-instruction abandons that instruction with no retire and no writes. Fetch restarts on the first edge after release.
- Latency with MemReady tied to 1:
  - Data-processing instruction: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Op and Funct are sampled only in DECODE and MEMADR. They must be stable from the IRWrite edge onward.
- MemReady is ignored in every state except FETCH, MEMREAD and MEMWRITE.
- The state register must never reach an illegal encoding. Any illegal encoding recovers to FETCH on the next edge.

## Structure
- A shared package holds:
  - the state enum (statetype);
  - the named encodings for ALUSrcA, ALUSrcB and ResultSrc;
  - the Op encodings OP_DP=00, OP_MEM=01, OP_BR=10.
- One sub-module is natural: instr_counter, a CNT_W-wide counter with enable and asynchronous active-low clear.
- The state register, next-state logic and output decode stay in mainfsm.

## Test plan
- Op=00, Funct=001000, MemReady=1: states are FETCH, DECODE, EXECUTER, ALUWB, FETCH. RegW is high only in cycle 4. InstrCount goes 0 to 1.
- Op=01, Funct=011001 (LDR), with MemReady=0 for the first 2 MEMREAD cycles: the bench sees 3 MEMREAD cycles with AdrSrc=1, then MEMWB with RegW=1 and ResultSrc=01. The instruction takes 7 cycles in total.
- Op=01, Funct=011000 (STR), with MemReady=0 for 1 cycle: MemW is high for 2 cycles, Retire pulses on the second, and the FSM returns to FETCH.
- Op=10: states are FETCH, DECODE, BRANCH. Branch=1 with ALUSrcB=01 and ResultSrc=10.
- Op=11: DECODE returns to FETCH. No Retire pulse and no write strobes.
- Assert reset=0 during MEMWRITE: MemW drops in the same cycle with no clock edge needed. After release, the FSM is in FETCH with InstrCount=0.
- Preload InstrCount to all-ones through a forced reset-free run, then retire once: InstrCount becomes 0.
